// File: rtl/output_stage_if.sv
// ---------------------------------------------------------------------------
// output_stage_if
// Bundles the tile handshake from the array controller and the simple
// dual-port output memory bus for the output_stage write-back engine.
//
//   START_CALC  level, high for the whole controller RUN phase
//   ACC         0 = overwrite tile, 1 = accumulate onto stored tile
//   ODST        output tile address {m, t}
//   ROW_VALID   ROW_DATA valid this cycle
//   ROW_DATA    LANES x PSUM_W signed lanes
//   ROW_READY   row accepted when ROW_VALID & ROW_READY
//   OM_REN/OM_RADDR/OM_RDATA   read port, data one cycle after OM_REN
//   OM_WEN/OM_WADDR/OM_WDATA   write port
//   Tile_Done   one-cycle pulse after the fourth row is written
//   BUSY        engine not idle
//
// slave  : the output_stage itself
// master : the surroundings (array controller + output memory)
// ---------------------------------------------------------------------------
interface output_stage_if #(
    parameter int LANES  = 4,
    parameter int PSUM_W = 16
);
    logic                      START_CALC;
    logic                      ACC;
    logic [3:0]                ODST;
    logic                      ROW_VALID;
    logic [LANES*PSUM_W-1:0]   ROW_DATA;
    logic                      ROW_READY;
    logic                      OM_REN;
    logic [5:0]                OM_RADDR;
    logic [LANES*PSUM_W-1:0]   OM_RDATA;
    logic                      OM_WEN;
    logic [5:0]                OM_WADDR;
    logic [LANES*PSUM_W-1:0]   OM_WDATA;
    logic                      Tile_Done;
    logic                      BUSY;

    modport slave (
        input  START_CALC, ACC, ODST, ROW_VALID, ROW_DATA, OM_RDATA,
        output ROW_READY, OM_REN, OM_RADDR, OM_WEN, OM_WADDR, OM_WDATA,
               Tile_Done, BUSY
    );

    modport master (
        output START_CALC, ACC, ODST, ROW_VALID, ROW_DATA, OM_RDATA,
        input  ROW_READY, OM_REN, OM_RADDR, OM_WEN, OM_WADDR, OM_WDATA,
               Tile_Done, BUSY
    );
endinterface

// File: rtl/output_stage.sv
// ---------------------------------------------------------------------------
// output_stage
// Tile write-back engine between the MAC array and output memory. Accepts
// four result rows per tile pass while START_CALC is high and writes each
// to address {ODST, row}, either overwriting or adding lane-wise onto the
// partial sum already stored. Pulses Tile_Done in the cycle the fourth
// row is written.
//
// Ports:
//   CLK  clock, rising edge
//   RST  synchronous active-high reset
//   bus  output_stage_if.slave (handshake + output memory ports)
//
// Build option:
//   OSTAGE_SAT_EN  when defined, accumulate saturates per lane to the signed
//                  PSUM_W range; otherwise it wraps modulo 2^PSUM_W.
// ---------------------------------------------------------------------------

// One lane of the accumulate adder.
module output_stage_lane #(
    parameter int PSUM_W = 16
) (
    input  logic [PSUM_W-1:0] a,
    input  logic [PSUM_W-1:0] b,
    output logic [PSUM_W-1:0] sum
);
`ifdef OSTAGE_SAT_EN
    localparam logic [PSUM_W-1:0] MAXV = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic [PSUM_W-1:0] MINV = {1'b1, {(PSUM_W-1){1'b0}}};
    logic [PSUM_W:0] full;

    // Sign-extended sum; the top two bits differ exactly on overflow and the
    // top bit then gives the true sign of the result.
    always_comb begin
        full = {a[PSUM_W-1], a} + {b[PSUM_W-1], b};
        if (full[PSUM_W] != full[PSUM_W-1])
            sum = full[PSUM_W] ? MINV : MAXV;
        else
            sum = full[PSUM_W-1:0];
    end
`else
    assign sum = a + b;
`endif
endmodule

module output_stage #(
    parameter int LANES  = 4,
    parameter int PSUM_W = 16
) (
    input  logic           CLK,
    input  logic           RST,
    output_stage_if.slave  bus
);
    localparam int ROW_W = LANES * PSUM_W;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [1:0]  row_cnt, row_cnt_nxt;
    logic [3:0]  odst_q;
    logic        acc_q;

    // Write stage: one registered row in flight toward memory.
    logic             wr_vld;
    logic             wr_acc;
    logic [5:0]       wr_addr;
    logic [ROW_W-1:0] row_q;

    logic        accept;
    logic        acc_sel;
    logic [3:0]  odst_sel;
    logic [5:0]  row_addr;

    logic [LANES-1:0][PSUM_W-1:0] lane_row, lane_mem, lane_sum;

    assign accept = (state == COLLECT) && bus.ROW_VALID;

    // Row 0 takes ODST/ACC live (they are latched on that acceptance);
    // rows 1-3 use the latched copy so ODST may move on early.
    assign acc_sel  = (row_cnt == 2'd0) ? bus.ACC  : acc_q;
    assign odst_sel = (row_cnt == 2'd0) ? bus.ODST : odst_q;
    assign row_addr = {odst_sel, row_cnt};

    // Next state
    always_comb begin
        state_nxt   = state;
        row_cnt_nxt = row_cnt;
        case (state)
            IDLE: begin
                row_cnt_nxt = 2'd0;
                if (bus.START_CALC) state_nxt = COLLECT;
            end
            COLLECT: begin
                if (accept) row_cnt_nxt = row_cnt + 2'd1;
                if (!bus.START_CALC) begin
                    // Abort: drop the partial tile, no Tile_Done.
                    state_nxt   = IDLE;
                    row_cnt_nxt = 2'd0;
                end else if (accept && row_cnt == 2'd3) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                row_cnt_nxt = 2'd0;
                state_nxt   = bus.START_CALC ? COLLECT : IDLE;
            end
            default: begin
                state_nxt   = IDLE;
                row_cnt_nxt = 2'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            row_cnt <= 2'd0;
            odst_q  <= '0;
            acc_q   <= 1'b0;
            wr_vld  <= 1'b0;
            wr_acc  <= 1'b0;
            wr_addr <= '0;
            row_q   <= '0;
        end else begin
            state   <= state_nxt;
            row_cnt <= row_cnt_nxt;
            if (accept && row_cnt == 2'd0) begin
                odst_q <= bus.ODST;
                acc_q  <= bus.ACC;
            end
            // An accepted row is always written next cycle, even if the
            // tile is aborted in the same cycle.
            wr_vld <= accept;
            if (accept) begin
                wr_acc  <= acc_sel;
                wr_addr <= row_addr;
                row_q   <= bus.ROW_DATA;
            end
        end
    end

    // Lane-wise accumulate of stored partial sum and registered row.
    assign lane_row = row_q;
    assign lane_mem = bus.OM_RDATA;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        output_stage_lane #(.PSUM_W(PSUM_W)) u_lane (
            .a   (lane_mem[i]),
            .b   (lane_row[i]),
            .sum (lane_sum[i])
        );
    end

    // Outputs: state-decoded handshake, read issued in the accept cycle,
    // write one cycle later. Idle buses are held at zero.
    assign bus.ROW_READY = (state == COLLECT);
    assign bus.BUSY      = (state != IDLE);
    assign bus.Tile_Done = (state == DRAIN);
    assign bus.OM_REN    = accept && acc_sel;
    assign bus.OM_RADDR  = bus.OM_REN ? row_addr : 6'd0;
    assign bus.OM_WEN    = wr_vld;
    assign bus.OM_WADDR  = wr_vld ? wr_addr : 6'd0;
    assign bus.OM_WDATA  = !wr_vld ? '0 : (wr_acc ? lane_sum : row_q);
endmodule

// File: tb/tb_output_stage.sv
module tb_output_stage;
    logic clk;
    logic rst;
    logic mem_clr;

    output_stage_if bus ();

    output_stage u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple dual-port output memory, one-cycle read latency.
    logic [63:0] mem [64];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            bus.OM_RDATA <= '0;
        end else begin
            if (bus.OM_WEN) mem[bus.OM_WADDR] <= bus.OM_WDATA;
            if (bus.OM_REN) bus.OM_RDATA <= mem[bus.OM_RADDR];
        end
    end

    typedef struct packed {
        logic        ready;
        logic        ren;
        logic [5:0]  raddr;
        logic        wen;
        logic [5:0]  waddr;
        logic [63:0] wdata;
        logic        done;
        logic        busy;
    } out_t;

    typedef struct {
        logic        rst;
        logic        start;
        logic        acc;
        logic [3:0]  odst;
        logic        valid;
        logic [63:0] data;
        out_t        exp;
    } vec_t;

    int checks   = 0;
    int failures = 0;

`ifdef OSTAGE_SAT_EN
    localparam logic [63:0] EXP21 = 64'h0003_0003_8000_7FFF;
`else
    localparam logic [63:0] EXP21 = 64'h0003_0003_7FF5_8010;
`endif
    localparam logic [63:0] M21  = 64'h0001_0001_8005_7FF0;
    localparam logic [63:0] ROW1 = 64'h0002_0002_FFF0_0020;

    function automatic logic [63:0] rep(input logic [15:0] x);
        return {x, x, x, x};
    endfunction

    function automatic out_t o(input logic rdy, input logic ren, input logic [5:0] ra,
                               input logic wen, input logic [5:0] wa, input logic [63:0] wd,
                               input logic dn, input logic bsy);
        out_t r;
        r.ready = rdy; r.ren = ren; r.raddr = ra; r.wen = wen;
        r.waddr = wa;  r.wdata = wd; r.done = dn; r.busy = bsy;
        return r;
    endfunction

    function automatic vec_t v(input logic r, input logic s, input logic a,
                               input logic [3:0] od, input logic vl,
                               input logic [63:0] d, input out_t e);
        vec_t t;
        t.rst = r; t.start = s; t.acc = a; t.odst = od;
        t.valid = vl; t.data = d; t.exp = e;
        return t;
    endfunction

    // Drive one cycle of inputs after the falling edge, sample before the
    // next rising edge.
    task automatic step(input vec_t t, input string nm);
        out_t act;
        @(negedge clk);
        rst            = t.rst;
        bus.START_CALC = t.start;
        bus.ACC        = t.acc;
        bus.ODST       = t.odst;
        bus.ROW_VALID  = t.valid;
        bus.ROW_DATA   = t.data;
        #2;
        act = o(bus.ROW_READY, bus.OM_REN, bus.OM_RADDR, bus.OM_WEN,
                bus.OM_WADDR, bus.OM_WDATA, bus.Tile_Done, bus.BUSY);
        checks++;
        if (act !== t.exp) begin
            failures++;
            $display("FAIL %s: got {rdy,ren,ra,wen,wa,wd,done,busy}=%h want %h",
                     nm, act, t.exp);
        end
    endtask

    vec_t tbl[$];
    out_t z;

    initial begin
        rst            = 1'b1;
        mem_clr        = 1'b1;
        bus.START_CALC = 1'b0;
        bus.ACC        = 1'b0;
        bus.ODST       = '0;
        bus.ROW_VALID  = 1'b0;
        bus.ROW_DATA   = '0;
        z = o(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        tbl.push_back(v(1, 0, 0, 0, 0, 0, z));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, z));
        // Overwrite, ODST=5; ROW_VALID in DRAIN must be ignored
        tbl.push_back(v(0, 1, 0, 5, 0, 0,        z));
        tbl.push_back(v(0, 1, 0, 5, 1, rep(1),   o(1, 0, 0, 0, 0,  0,      0, 1)));
        tbl.push_back(v(0, 1, 0, 5, 1, rep(2),   o(1, 0, 0, 1, 20, rep(1), 0, 1)));
        tbl.push_back(v(0, 1, 0, 5, 1, rep(3),   o(1, 0, 0, 1, 21, rep(2), 0, 1)));
        tbl.push_back(v(0, 1, 0, 5, 1, rep(4),   o(1, 0, 0, 1, 22, rep(3), 0, 1)));
        tbl.push_back(v(0, 1, 0, 5, 1, rep(9),   o(0, 0, 0, 1, 23, rep(4), 1, 1)));
        // Back-to-back preload tile at ODST=5 for the accumulate test
        tbl.push_back(v(0, 1, 0, 5, 1, rep(16'h0010), o(1, 0, 0, 0, 0,  0,              0, 1)));
        tbl.push_back(v(0, 1, 0, 5, 1, M21,           o(1, 0, 0, 1, 20, rep(16'h0010), 0, 1)));
        tbl.push_back(v(0, 1, 0, 5, 1, rep(16'hFFFF), o(1, 0, 0, 1, 21, M21,           0, 1)));
        tbl.push_back(v(0, 1, 0, 5, 1, rep(16'h1234), o(1, 0, 0, 1, 22, rep(16'hFFFF), 0, 1)));
        tbl.push_back(v(0, 0, 0, 5, 0, 0,             o(0, 0, 0, 1, 23, rep(16'h1234), 1, 1)));
        tbl.push_back(v(0, 0, 0, 5, 0, 0,             z));
        // Accumulate, ODST=5; ODST/ACC changed after row 0 must be ignored
        tbl.push_back(v(0, 1, 1, 5, 0, 0,             z));
        tbl.push_back(v(0, 1, 1, 5, 1, rep(16'h0005), o(1, 1, 20, 0, 0,  0,              0, 1)));
        tbl.push_back(v(0, 1, 0, 9, 1, ROW1,          o(1, 1, 21, 1, 20, rep(16'h0015), 0, 1)));
        tbl.push_back(v(0, 1, 0, 9, 1, rep(16'h0100), o(1, 1, 22, 1, 21, EXP21,         0, 1)));
        tbl.push_back(v(0, 1, 0, 9, 1, rep(16'h0001), o(1, 1, 23, 1, 22, rep(16'h00FF), 0, 1)));
        tbl.push_back(v(0, 0, 0, 9, 0, 0,             o(0, 0, 0,  1, 23, rep(16'h1235), 1, 1)));
        tbl.push_back(v(0, 0, 0, 9, 0, 0,             z));
        // Back-to-back ODST 0 then 1: Tile_Done on cycles 5 and 10
        tbl.push_back(v(0, 1, 0, 0, 0, 0,             z));
        tbl.push_back(v(0, 1, 0, 0, 1, rep(16'h00A0), o(1, 0, 0, 0, 0, 0,              0, 1)));
        tbl.push_back(v(0, 1, 0, 0, 1, rep(16'h00A1), o(1, 0, 0, 1, 0, rep(16'h00A0), 0, 1)));
        tbl.push_back(v(0, 1, 0, 0, 1, rep(16'h00A2), o(1, 0, 0, 1, 1, rep(16'h00A1), 0, 1)));
        tbl.push_back(v(0, 1, 0, 0, 1, rep(16'h00A3), o(1, 0, 0, 1, 2, rep(16'h00A2), 0, 1)));
        tbl.push_back(v(0, 1, 0, 1, 1, rep(16'hDEAD), o(0, 0, 0, 1, 3, rep(16'h00A3), 1, 1)));
        tbl.push_back(v(0, 1, 0, 1, 1, rep(16'h00B0), o(1, 0, 0, 0, 0, 0,              0, 1)));
        tbl.push_back(v(0, 1, 0, 1, 1, rep(16'h00B1), o(1, 0, 0, 1, 4, rep(16'h00B0), 0, 1)));
        tbl.push_back(v(0, 1, 0, 1, 1, rep(16'h00B2), o(1, 0, 0, 1, 5, rep(16'h00B1), 0, 1)));
        tbl.push_back(v(0, 1, 0, 1, 1, rep(16'h00B3), o(1, 0, 0, 1, 6, rep(16'h00B2), 0, 1)));
        tbl.push_back(v(0, 0, 0, 1, 0, 0,             o(0, 0, 0, 1, 7, rep(16'h00B3), 1, 1)));
        tbl.push_back(v(0, 0, 0, 1, 0, 0,             z));

        for (int i = 0; i < tbl.size(); i++) begin
            if (i == 2) mem_clr = 1'b0;
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Abort after two rows: write of row 1 still lands, no Tile_Done,
        // next tile restarts at row 0 (address {3,0} = 12).
        step(v(0, 1, 0, 2, 0, 0,             z),                                     "abort_idle");
        step(v(0, 1, 0, 2, 1, rep(16'h00C0), o(1, 0, 0,  0, 0,  0,             0, 1)), "abort_r0");
        step(v(0, 1, 0, 2, 1, rep(16'h00C1), o(1, 0, 0,  1, 8,  rep(16'h00C0), 0, 1)), "abort_r1");
        step(v(0, 0, 0, 2, 0, 0,             o(1, 0, 0,  1, 9,  rep(16'h00C1), 0, 1)), "abort_drop");
        step(v(0, 0, 0, 2, 0, 0,             z),                                     "abort_idle2");
        step(v(0, 1, 1, 3, 0, 0,             z),                                     "restart_idle");
        step(v(0, 1, 1, 3, 1, rep(16'h0007), o(1, 1, 12, 0, 0,  0,             0, 1)), "restart_r0");
        step(v(0, 1, 1, 3, 0, 0,             o(1, 0, 0,  1, 12, rep(16'h0007), 0, 1)), "restart_wr");

        // Reset mid-COLLECT with a row offered: row dropped, outputs clear.
        step(v(1, 1, 1, 3, 1, rep(16'h0008), o(1, 1, 13, 0, 0,  0,             0, 1)), "rst_cycle");
        step(v(0, 1, 1, 3, 1, rep(16'h0008), z),                                     "rst_after");
        step(v(0, 1, 1, 3, 1, rep(16'h0009), o(1, 1, 12, 0, 0,  0,             0, 1)), "rst_r0");
        step(v(0, 0, 0, 3, 0, 0,             o(1, 0, 0,  1, 12, rep(16'h0010), 0, 1)), "rst_r0_wr");
        step(v(0, 0, 0, 3, 0, 0,             z),                                     "rst_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
